// File: rtl/qft_seq_ctrl.sv
// qft_seq_ctrl: time-multiplexed sequencer for the 3-qubit QFT.
// One shared complex MAC evaluates y[j] = sum_i x[i] * w^(i*j) / sqrt(8),
// w = e^(i*pi/4), one term per cycle (8 cycles per output amplitude).
// Outputs are streamed with a valid/ready handshake.
// Optional feature: define QFT_INVERSE_EN to add the 'inv' input, which
// selects conjugate twiddles (inverse QFT) for the transform being started.
module qft_seq_ctrl #(
  parameter int W     = 17,
  parameter int FRAC  = 15,
  parameter int ACC_W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_addr,
  input  logic [W-1:0] in_re,
  input  logic [W-1:0] in_im,
  input  logic         start,
`ifdef QFT_INVERSE_EN
  input  logic         inv,
`endif
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [2:0]   out_state,
  output logic [W-1:0] out_re,
  output logic [W-1:0] out_im,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Term index i (inner loop) and output index j (outer loop)
  logic [2:0] i_q, i_d;
  logic [2:0] j_q, j_d;

  // Complex accumulator with guard bits for the 8-term sum
  logic signed [ACC_W-1:0] acc_re_q, acc_re_d;
  logic signed [ACC_W-1:0] acc_im_q, acc_im_d;

  // Input amplitude store
  logic signed [W-1:0] x_re_q [8];
  logic signed [W-1:0] x_re_d [8];
  logic signed [W-1:0] x_im_q [8];
  logic signed [W-1:0] x_im_d [8];

`ifdef QFT_INVERSE_EN
  // Transform direction latched when start is taken
  logic inv_q, inv_d;
`endif

  // Registered outputs
  logic         in_ready_q, in_ready_d;
  logic         busy_q, busy_d;
  logic         out_valid_q, out_valid_d;
  logic [2:0]   out_state_q, out_state_d;
  logic [W-1:0] out_re_q, out_re_d;
  logic [W-1:0] out_im_q, out_im_d;
  logic         done_q, done_d;

  // Twiddle ROM, real part, pre-scaled by 1/sqrt(8)
  function automatic logic signed [W-1:0] tw_re(input logic [2:0] k);
    case (k)
      3'd0:    tw_re = 17'sd11585;
      3'd1:    tw_re = 17'sd8192;
      3'd2:    tw_re = 17'sd0;
      3'd3:    tw_re = -17'sd8192;
      3'd4:    tw_re = -17'sd11585;
      3'd5:    tw_re = -17'sd8192;
      3'd6:    tw_re = 17'sd0;
      default: tw_re = 17'sd8192;
    endcase
  endfunction

  // Twiddle ROM, imaginary part, pre-scaled by 1/sqrt(8)
  function automatic logic signed [W-1:0] tw_im(input logic [2:0] k);
    case (k)
      3'd0:    tw_im = 17'sd0;
      3'd1:    tw_im = 17'sd8192;
      3'd2:    tw_im = 17'sd11585;
      3'd3:    tw_im = 17'sd8192;
      3'd4:    tw_im = 17'sd0;
      3'd5:    tw_im = -17'sd8192;
      3'd6:    tw_im = -17'sd11585;
      default: tw_im = -17'sd8192;
    endcase
  endfunction

  // One real partial product: full-precision multiply, arithmetic shift by
  // FRAC, truncate (wrap) to W bits, then sign-extend to the accumulator.
  function automatic logic signed [ACC_W-1:0] mul_part(
    input logic signed [W-1:0] a,
    input logic signed [W-1:0] b
  );
    logic signed [2*W-1:0] p;
    logic signed [W-1:0]   t;
    p = (2*W)'(a) * (2*W)'(b);
    t = W'(p >>> FRAC);
    return ACC_W'(t);
  endfunction

  // Current MAC term: x[i] times twiddle at (i*j) mod 8 (conjugated if inverse)
  logic [2:0]              tw_k;
  logic signed [W-1:0]     cur_xr, cur_xi;
  logic signed [W-1:0]     cur_tr, cur_ti;
  logic signed [ACC_W-1:0] prod_re, prod_im;

  // Select operands for the term being accumulated this cycle
  always_comb begin
    tw_k = i_q * j_q;
`ifdef QFT_INVERSE_EN
    if (inv_q) begin
      tw_k = 3'd0 - tw_k;
    end
`endif
    cur_xr  = x_re_q[i_q];
    cur_xi  = x_im_q[i_q];
    cur_tr  = tw_re(tw_k);
    cur_ti  = tw_im(tw_k);
    prod_re = mul_part(cur_xr, cur_tr) - mul_part(cur_xi, cur_ti);
    prod_im = mul_part(cur_xr, cur_ti) + mul_part(cur_xi, cur_tr);
  end

  // Next-state logic for the sequencer, store, accumulator and outputs
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    acc_re_d    = acc_re_q;
    acc_im_d    = acc_im_q;
    x_re_d      = x_re_q;
    x_im_d      = x_im_q;
`ifdef QFT_INVERSE_EN
    inv_d       = inv_q;
`endif
    out_state_d = out_state_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A write presented together with start lands before the MAC reads x[]
        if (in_valid) begin
          x_re_d[in_addr] = $signed(in_re);
          x_im_d[in_addr] = $signed(in_im);
        end
        if (start) begin
          state_d = S_MAC;
          i_d     = 3'd0;
          j_d     = 3'd0;
`ifdef QFT_INVERSE_EN
          inv_d   = inv;
`endif
        end
      end

      S_MAC: begin
        if (i_q == 3'd0) begin
          acc_re_d = prod_re;
          acc_im_d = prod_im;
        end else begin
          acc_re_d = acc_re_q + prod_re;
          acc_im_d = acc_im_q + prod_im;
        end
        if (i_q == 3'd7) begin
          // Last term: present the wrapped sum and hold it until accepted
          state_d     = S_OUT;
          out_state_d = j_q;
          out_re_d    = W'(acc_re_d);
          out_im_d    = W'(acc_im_d);
        end else begin
          i_d = i_q + 3'd1;
        end
      end

      S_OUT: begin
        if (out_ready) begin
          i_d = 3'd0;
          if (j_q == 3'd7) begin
            state_d = S_IDLE;
            j_d     = 3'd0;
            done_d  = 1'b1;
          end else begin
            state_d = S_MAC;
            j_d     = j_q + 3'd1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d  = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    out_valid_d = (state_d == S_OUT);
  end

  // State and output registers; reset abandons any transform in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      i_q         <= 3'd0;
      j_q         <= 3'd0;
      acc_re_q    <= '0;
      acc_im_q    <= '0;
      for (int n = 0; n < 8; n++) begin
        x_re_q[n] <= '0;
        x_im_q[n] <= '0;
      end
`ifdef QFT_INVERSE_EN
      inv_q       <= 1'b0;
`endif
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_state_q <= 3'd0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      acc_re_q    <= acc_re_d;
      acc_im_q    <= acc_im_d;
      x_re_q      <= x_re_d;
      x_im_q      <= x_im_d;
`ifdef QFT_INVERSE_EN
      inv_q       <= inv_d;
`endif
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_state_q <= out_state_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_state = out_state_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign done      = done_q;

endmodule

// File: tb/tb_qft_seq_ctrl.sv
// Testbench for qft_seq_ctrl: directed transforms checked every output
// cycle against an arithmetic model of the 8-point scaled DFT, plus literal
// expectations for the basis and superposition cases.
module tb_qft_seq_ctrl;
  localparam int W = 17;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_addr;
  logic [W-1:0] in_re;
  logic [W-1:0] in_im;
  logic         start;
`ifdef QFT_INVERSE_EN
  logic         inv;
`endif
  logic         busy;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   out_state;
  logic [W-1:0] out_re;
  logic [W-1:0] out_im;
  logic         done;

  always #5 clk = ~clk;

  qft_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_re     (in_re),
    .in_im     (in_im),
    .start     (start),
`ifdef QFT_INVERSE_EN
    .inv       (inv),
`endif
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .out_re    (out_re),
    .out_im    (out_im),
    .done      (done)
  );

  int vectors = 0;
  int miscompares = 0;

  int twr [8] = '{11585, 8192, 0, -8192, -11585, -8192, 0, 8192};
  int twi [8] = '{0, 8192, 11585, 8192, 0, -8192, -11585, -8192};

  int mdl_re [8];
  int mdl_im [8];
  int exp_re [8];
  int exp_im [8];
  int got_re [8];
  int got_im [8];
  int fw_re  [8];
  int fw_im  [8];

  int           exp_j;
  int           done_cnt;
  bit           prev_stall;
  bit           saw_valid;
  logic [W-1:0] prev_re, prev_im;
  logic [2:0]   prev_st;

  function automatic int s17(longint v);
    longint t;
    t = v & 64'h1FFFF;
    if (t >= 65536) t = t - 131072;
    return int'(t);
  endfunction

  function automatic int sx(logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int part(int a, int b);
    longint p;
    p = longint'(a) * longint'(b);
    return s17(p >>> 15);
  endfunction

  // y[j] = sum_i x[i]*tw[(i*j) mod 8], each real partial wrapped to 17 bits
  function automatic void model(bit inv_v);
    for (int j = 0; j < 8; j++) begin
      longint sr, si;
      sr = 0;
      si = 0;
      for (int i = 0; i < 8; i++) begin
        int k;
        k = (i * j) % 8;
        if (inv_v) k = (8 - k) % 8;
        sr += part(mdl_re[i], twr[k]) - part(mdl_im[i], twi[k]);
        si += part(mdl_re[i], twi[k]) + part(mdl_im[i], twr[k]);
      end
      exp_re[j] = s17(sr);
      exp_im[j] = s17(si);
    end
  endfunction

  task automatic chk(string nm, int act, int expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic chk_tol(string nm, int act, int expv, int tol);
    vectors++;
    if (act < expv - tol || act > expv + tol) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d +/-%0d", nm, act, expv, tol);
    end
  endtask

  // One clock: compare outputs at the falling edge, then advance past the rising edge
  task automatic tick();
    @(negedge clk);
    saw_valid = 1'b0;
    if (!rst) begin
      if (done) done_cnt++;
      if (out_valid) begin
        saw_valid = 1'b1;
        if (exp_j > 7) begin
          chk("extra_output", exp_j, 7);
        end else begin
          chk("out_state", int'(out_state), exp_j);
          chk("out_re", sx(out_re), exp_re[exp_j]);
          chk("out_im", sx(out_im), exp_im[exp_j]);
          if (prev_stall) begin
            chk("hold_re", sx(out_re), sx(prev_re));
            chk("hold_im", sx(out_im), sx(prev_im));
            chk("hold_state", int'(out_state), int'(prev_st));
          end
          got_re[exp_j] = sx(out_re);
          got_im[exp_j] = sx(out_im);
          prev_re    = out_re;
          prev_im    = out_im;
          prev_st    = out_state;
          prev_stall = !out_ready;
          if (out_ready) exp_j++;
        end
      end else begin
        prev_stall = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(int addr, int re, int im);
    in_valid = 1'b1;
    in_addr  = 3'(addr);
    in_re    = W'(re);
    in_im    = W'(im);
    tick();
    in_valid = 1'b0;
    mdl_re[addr] = re;
    mdl_im[addr] = im;
  endtask

  // Start a transform and drain all 8 outputs; stall_j<0 means no backpressure
  task automatic run(bit inv_v, int stall_j);
    int cyc, first, last, stall_cnt;
    model(inv_v);
    exp_j      = 0;
    done_cnt   = 0;
    prev_stall = 1'b0;
    first      = -1;
    last       = -1;
    stall_cnt  = 0;
    start      = 1'b1;
`ifdef QFT_INVERSE_EN
    inv        = inv_v;
`endif
    out_ready  = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    chk("in_ready_while_busy", int'(in_ready), 0);
    cyc = 0;
    while (exp_j < 8 && cyc < 400) begin
      in_valid  = 1'b0;
      start     = 1'b0;
      out_ready = 1'b1;
      if (stall_j >= 0 && out_valid && exp_j == stall_j && stall_cnt < 5) begin
        out_ready = 1'b0;
        stall_cnt++;
        in_valid  = 1'b1;
        in_addr   = 3'(stall_cnt);
        in_re     = 17'd777;
        in_im     = 17'd555;
        start     = 1'b1;
      end
      if (stall_j >= 0 && cyc == 3) begin
        in_valid = 1'b1;
        in_addr  = 3'd0;
        in_re    = 17'd4321;
        in_im    = 17'd1234;
        start    = 1'b1;
      end
      tick();
      cyc++;
      if (saw_valid && first < 0) first = cyc;
      if (exp_j == 8 && last < 0) last = cyc;
    end
    in_valid  = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    chk("transform_complete", exp_j, 8);
    chk("first_valid_cycle", first, 9);
    chk("last_handshake_cycle", last, (stall_j >= 0) ? 77 : 72);
    tick();
    tick();
    chk("done_pulses", done_cnt, 1);
    chk("in_ready_after", int'(in_ready), 1);
    chk("busy_after", int'(busy), 0);
    chk("out_valid_after", int'(out_valid), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_addr   = 3'd0;
    in_re     = '0;
    in_im     = '0;
    start     = 1'b0;
`ifdef QFT_INVERSE_EN
    inv       = 1'b0;
`endif
    out_ready = 1'b1;
    exp_j     = 0;
    done_cnt  = 0;
    prev_stall = 1'b0;
    for (int n = 0; n < 8; n++) begin
      mdl_re[n] = 0;
      mdl_im[n] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_out_state", int'(out_state), 0);
    chk("rst_out_re", sx(out_re), 0);
    chk("rst_out_im", sx(out_im), 0);

    // Basis |0>: every output is 1/sqrt8
    wr(0, 32768, 0);
    run(1'b0, -1);
    for (int j = 0; j < 8; j++) begin
      chk_tol("basis0_re", got_re[j], 11585, 1);
      chk_tol("basis0_im", got_im[j], 0, 1);
    end

    // Basis |3>, written in the same cycle as start
    wr(0, 0, 0);
    in_valid = 1'b1;
    in_addr  = 3'd3;
    in_re    = 17'd32768;
    in_im    = 17'd0;
    mdl_re[3] = 32768;
    mdl_im[3] = 0;
    run(1'b0, -1);
    chk_tol("basis3_y1_re", got_re[1], -8192, 1);
    chk_tol("basis3_y1_im", got_im[1], 8192, 1);
    chk_tol("basis3_y2_re", got_re[2], 0, 1);
    chk_tol("basis3_y2_im", got_im[2], -11585, 1);
    chk_tol("basis3_y4_re", got_re[4], -11585, 1);
    chk_tol("basis3_y4_im", got_im[4], 0, 1);

    // Superposition of |0> and |1>
    wr(3, 0, 0);
    wr(0, 23170, 0);
    wr(1, 23170, 0);
    run(1'b0, -1);
    chk_tol("sup_y0_re", got_re[0], 16382, 4);
    chk_tol("sup_y0_im", got_im[0], 0, 4);
    chk_tol("sup_y4_re", got_re[4], 0, 4);
    chk_tol("sup_y4_im", got_im[4], 0, 4);
    chk_tol("sup_y2_re", got_re[2], 8191, 4);
    chk_tol("sup_y2_im", got_im[2], 8191, 4);
    chk("sup_y1_re_exact", got_re[1], 13983);
    chk("sup_y1_im_exact", got_im[1], 5792);
    for (int j = 0; j < 8; j++) begin
      fw_re[j] = got_re[j];
      fw_im[j] = got_im[j];
    end

    // Backpressure at j=3 with ignored write/start pulses while busy
    run(1'b0, 3);
    chk_tol("bp_y0_re", got_re[0], 16382, 4);
    chk_tol("bp_y2_re", got_re[2], 8191, 4);

`ifdef QFT_INVERSE_EN
    // Inverse of the superposition result recovers the input
    for (int n = 0; n < 8; n++) begin
      wr(n, fw_re[n], fw_im[n]);
    end
    run(1'b1, -1);
    chk_tol("inv_x0_re", got_re[0], 23170, 16);
    chk_tol("inv_x1_re", got_re[1], 23170, 16);
    for (int j = 0; j < 8; j++) begin
      if (j > 1) chk_tol("inv_other_re", got_re[j], 0, 16);
      chk_tol("inv_im", got_im[j], 0, 16);
    end
`endif

    // Reset in the middle of MAC
    wr(0, 32768, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int n = 0; n < 8; n++) begin
      mdl_re[n] = 0;
      mdl_im[n] = 0;
    end
    tick();
    run(1'b0, -1);
    for (int j = 0; j < 8; j++) begin
      chk("cleared_re", got_re[j], 0);
      chk("cleared_im", got_im[j], 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
